// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package inst_fetch_buffer_pkg;

  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  // NOP returned whenever the instruction is not available.
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IFB_IDLE = 2'd0,
    IFB_FILL = 2'd1,
    IFB_LAST = 2'd2
  } ifb_state_e;

  // Big-endian word assembly: the lowest-addressed byte is the most significant.
  function automatic logic [INST_W-1:0] assemble_word(
    input logic [BYTE_W-1:0] b0,
    input logic [BYTE_W-1:0] b1,
    input logic [BYTE_W-1:0] b2,
    input logic [BYTE_W-1:0] b3
  );
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/inst_fetch_buffer.sv
// One-line instruction fetch buffer in front of a byte-wide backing memory.
// Hits are served combinationally; a miss stalls the pipeline while the line
// is refilled one byte per cycle from a memory with one cycle of read latency.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int MEM_AW     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              stallreq_o,
  input  logic              flush_i,
  output logic              mem_re_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i
);

  localparam int N     = 4 * LINE_WORDS;
  localparam int OFF   = $clog2(N);
  localparam int TAG_W = MEM_AW - OFF;

  ifb_state_e       state_q, state_d;
  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
  logic [OFF-1:0]   cnt_q, cnt_d;

  logic [7:0]       line_q [N];
  logic             buf_we;
  logic [OFF-1:0]   buf_waddr;

  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic [OFF-1:0]   rd_base;
  logic [31:0]      rd_word;

  // Address bits above the backing-memory width alias onto the same line.
  logic unused_addr_hi;
  assign unused_addr_hi = ^rom_addr_i[31:MEM_AW];

  assign req_tag = rom_addr_i[MEM_AW-1:OFF];

  // A flush in flight turns any would-be hit into a stall.
  assign hit = valid_q && (req_tag == tag_q) && (state_q == IFB_IDLE) && !flush_i;

  // Byte offset of the addressed word inside the line (bits [1:0] dropped).
  assign rd_base = rom_addr_i[OFF-1:0] & ~OFF'(3);
  assign rd_word = assemble_word(line_q[rd_base],
                                 line_q[rd_base | OFF'(1)],
                                 line_q[rd_base | OFF'(2)],
                                 line_q[rd_base | OFF'(3)]);

  // Control and tag state; reset returns straight to an empty IDLE buffer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IFB_IDLE;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      fill_tag_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      fill_tag_q <= fill_tag_d;
      cnt_q      <= cnt_d;
    end
  end

  // Line storage; writes only happen during a refill.
  // NOTE: the byte array is deliberately not reset -- valid_q gates every read,
  // and leaving it unreset lets it map onto plain RAM/flops without reset logic.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_q[buf_waddr] <= mem_data_i;
    end
  end

  // Next-state logic: miss detection, byte-by-byte refill, flush abort.
  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    fill_tag_d = fill_tag_q;
    cnt_d      = cnt_q;
    buf_we     = 1'b0;
    buf_waddr  = cnt_q - OFF'(1);

    if (flush_i) begin
      // Flush wins over everything: drop the line and any refill in progress.
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = IFB_IDLE;
    end else begin
      unique case (state_q)
        IFB_IDLE: begin
          if (rom_ce_i && !hit) begin
            fill_tag_d = req_tag;
            valid_d    = 1'b0;
            cnt_d      = '0;
            state_d    = IFB_FILL;
          end
        end
        IFB_FILL: begin
          // The byte returned now belongs to the address issued last cycle.
          buf_we = (cnt_q != '0);
          if (cnt_q == OFF'(N - 1)) begin
            state_d = IFB_LAST;
          end else begin
            cnt_d = cnt_q + OFF'(1);
          end
        end
        IFB_LAST: begin
          buf_we    = 1'b1;
          buf_waddr = OFF'(N - 1);
          valid_d   = 1'b1;
          tag_d     = fill_tag_q;
          cnt_d     = '0;
          state_d   = IFB_IDLE;
        end
        default: begin
          state_d = IFB_IDLE;
        end
      endcase
    end
  end

  // Outputs: memory strobe tracks FILL; fetch port is forced quiet in reset.
  always_comb begin
    mem_re_o   = 1'b0;
    mem_addr_o = '0;
    stallreq_o = 1'b0;
    rom_data_o = ZERO_WORD;

    if (state_q == IFB_FILL) begin
      mem_re_o   = 1'b1;
      mem_addr_o = {fill_tag_q, cnt_q};
    end

    if (rst && rom_ce_i) begin
      stallreq_o = !hit;
      rom_data_o = hit ? rd_word : ZERO_WORD;
    end
  end

endmodule
